gpio_input_conditioner: RTL and testbench
=========================================

# gpio_input_conditioner

Parametrised conditioning stage for the board's slide switches and push buttons, placed between the top-level pins and the MicroBlaze GPIO input channels. Each channel has per-channel polarity correction, a two-flop synchroniser, a counter-based debouncer, rise/fall pulse generation and a sticky event register. The sticky register is cleared by software through a GPIO output mask. Software can therefore poll debounced levels and latched edges instead of raw, bouncing pins.

## Interface
Parameters:
- N_CH, default 20: number of channels (16 switches + 4 buttons); legal range 1..32.
- DEBOUNCE_CYCLES, default 1_000_000: consecutive disagreeing cycles required before the debounced level flips (10 ms at 100 MHz); legal minimum 2.
- INVERT_MASK, default '0 (N_CH bits): bit i = 1 inverts raw_in[i] before synchronisation, for active-low pins.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high reset.
- raw_in  in  N_CH  asynchronous pin inputs.
- clear_mask  in  N_CH  per-channel sticky clear, sampled every edge.
- level_out  out  N_CH  debounced, polarity-corrected level.
- rise_pulse  out  N_CH  one-cycle strobe when level_out[i] goes 0->1.
- fall_pulse  out  N_CH  one-cycle strobe when level_out[i] goes 1->0.
- event_sticky  out  N_CH  latched "any edge since last clear" per channel.
- any_event  out  1  OR-reduction of event_sticky.

## Operation
- Input path: raw_in ^ INVERT_MASK feeds two flops, s1 then s2, per channel. No logic sits between s1 and s2.
- Debounce counter: one per channel, width $clog2(DEBOUNCE_CYCLES).
  - If s2[i] == level_out[i], the counter is set to 0.
  - If s2[i] != level_out[i] and counter < DEBOUNCE_CYCLES-1, the counter increments.
  - If s2[i] != level_out[i] and counter == DEBOUNCE_CYCLES-1, level_out[i] toggles and the counter is set to 0.
  - Net effect: the level flips only after DEBOUNCE_CYCLES consecutive mismatch cycles. Any single matching cycle restarts the count.
  - The counter never wraps.
- Edge strobes: rise_pulse[i] and fall_pulse[i] are registered and asserted on the same edge that toggles level_out[i], for exactly one cycle. They are never both high.
- Sticky register, per channel, evaluated at each edge:
  - An edge strobe in the next state sets event_sticky[i].
  - Otherwise, clear_mask[i] = 1 clears event_sticky[i].
  - Otherwise, event_sticky[i] holds.
  - Set has priority over a simultaneous clear, so no event is lost.
  - clear_mask is level-sensitive: holding it high keeps the bit clear except on cycles where a new edge sets it.
- any_event is a combinational OR of the event_sticky flops.
- Channels are fully independent. Simultaneous activity on several channels is handled in parallel.
- Reset clears every flop: s1, s2, counters, level_out, pulses, sticky.
  - Reset behaves as an ordinary synchronous load and may arrive mid-debounce; partial counts are discarded.
  - A channel whose corrected input is 1 while reset is held reports a normal rise (pulse + sticky) one full debounce latency after reset deasserts.

## Timing
- Reset values: every output is 0.
- Latency: a corrected raw change first sampled by s1 at edge E0 appears on level_out, rise/fall_pulse and event_sticky at edge E0+DEBOUNCE_CYCLES+1. That is DEBOUNCE_CYCLES+2 edges counting E0, provided the input is stable throughout.
- A mismatch run of DEBOUNCE_CYCLES-1 cycles produces no output change.
- Pulse width: exactly 1 cycle. The minimum spacing between successive edges on one channel is DEBOUNCE_CYCLES+? cycles, bounded below by DEBOUNCE_CYCLES.
- Clear: a clear_mask[i] sampled at edge E makes event_sticky[i] 0 after E, unless an edge strobe is generated at E.
- any_event follows event_sticky in the same cycle, with no extra delay.

## Test plan
Bench configuration unless noted: N_CH=4, DEBOUNCE_CYCLES=4, INVERT_MASK=4'b1000.
1. Reset with raw_in=4'b1000 held through reset and after release.
   - During reset, all outputs are 0.
   - After release, channel 3 corrected input = 0, so there are no pulses and any_event stays 0 indefinitely.
2. Clean rise: raw_in[0] 0->1 before edge E0 and held.
   - level_out[0]=1 and rise_pulse[0]=1 after E0+5, for one cycle only.
   - event_sticky[0]=1 and any_event=1 after E0+5.
   - Other channels unchanged.
3. Bounce rejection: raw_in[1] high 3 cycles, low 1, high 3, low.
   - level_out[1] never changes; no pulses.
   - Then hold high for 6 cycles: exactly one rise_pulse[1], 6 edges after the first sample of the final high.
4. Clear/set collision: with event_sticky[0]=1, drive raw_in[0] low and assert clear_mask[0] on exactly the edge where fall_pulse[0] fires.
   - event_sticky[0] stays 1.
   - clear_mask[0] one cycle later drives it to 0, and any_event goes 0.
5. Active-low channel: raw_in[3] 1->0 and held.
   - rise_pulse[3] after the 6-edge latency, level_out[3]=1.
   - raw_in[3] back to 1 gives fall_pulse[3].
6. Reset mid-debounce: raw_in[2] high, with reset asserted for 1 cycle on the 3rd edge and raw held high.
   - No rise occurs before reset.
   - After reset deasserts, rise_pulse[2] fires a full 6 edges after the first post-reset sample.

Source files
------------

// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner
// Conditions slide-switch and push-button pins for the MicroBlaze GPIO inputs.
// Each channel gets polarity correction, a two-flop synchroniser, a
// counter-based debouncer, one-cycle rise/fall strobes and a sticky event bit
// that software clears through clear_mask.
module gpio_input_conditioner #(
    parameter int              N_CH            = 20,
    parameter int              DEBOUNCE_CYCLES = 1_000_000,
    parameter logic [N_CH-1:0] INVERT_MASK     = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] raw_in,
    input  logic [N_CH-1:0] clear_mask,
    output logic [N_CH-1:0] level_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic [N_CH-1:0] event_sticky,
    output logic            any_event
);

    // DEBOUNCE_CYCLES-1 always fits in $clog2(DEBOUNCE_CYCLES) bits, so the
    // counter can reach its terminal value without ever wrapping.
    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [N_CH-1:0] s1_q, s1_d;
    logic [N_CH-1:0] s2_q, s2_d;
    logic [N_CH-1:0] level_q, level_d;
    logic [N_CH-1:0] rise_q, rise_d;
    logic [N_CH-1:0] fall_q, fall_d;
    logic [N_CH-1:0] sticky_q, sticky_d;
    logic [CW-1:0]   cnt_q [N_CH];
    logic [CW-1:0]   cnt_d [N_CH];

    // Next-state logic: synchroniser shift, per-channel debounce, edge strobes
    // derived from the level toggle, and sticky set-over-clear.
    always_comb begin
        s1_d    = raw_in ^ INVERT_MASK;
        s2_d    = s1_q;
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    level_d[i] = ~level_q[i];
                    rise_d[i]  = ~level_q[i];
                    fall_d[i]  = level_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        sticky_d = rise_d | fall_d | (sticky_q & ~clear_mask);
    end

    // State registers; reset is a plain synchronous load that discards any
    // partial debounce count.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            level_q  <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            sticky_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            sticky_q <= sticky_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign level_out    = level_q;
    assign rise_pulse   = rise_q;
    assign fall_pulse   = fall_q;
    assign event_sticky = sticky_q;
    assign any_event    = |sticky_q;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// tb_gpio_input_conditioner
// Directed scenarios followed by random pin activity, all compared every cycle
// against a timestamp-based behavioural model of the conditioner.
module tb_gpio_input_conditioner;

    localparam int         N   = 4;
    localparam int         DC  = 4;
    localparam logic [3:0] INV = 4'b1000;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] raw_in;
    logic [3:0] clear_mask;
    logic [3:0] level_out;
    logic [3:0] rise_pulse;
    logic [3:0] fall_pulse;
    logic [3:0] event_sticky;
    logic       any_event;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: a two-stage delay of the corrected pin, the
    // debounced level, and the cycle stamp of the last sample agreeing with it.
    logic [3:0] m_p1     = '0;
    logic [3:0] m_p2     = '0;
    logic [3:0] m_lvl    = '0;
    logic [3:0] m_rise   = '0;
    logic [3:0] m_fall   = '0;
    logic [3:0] m_sticky = '0;
    longint     m_last [N];
    longint     cyc = 0;

    gpio_input_conditioner #(
        .N_CH            (N),
        .DEBOUNCE_CYCLES (DC),
        .INVERT_MASK     (INV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .raw_in       (raw_in),
        .clear_mask   (clear_mask),
        .level_out    (level_out),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .event_sticky (event_sticky),
        .any_event    (any_event)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Behavioural model: a level flips once the synchronised input has
    // disagreed with it for DC consecutive edges since it last agreed.
    always @(posedge clk) begin
        logic [3:0] sync;
        cyc++;
        if (reset) begin
            m_p1     = '0;
            m_p2     = '0;
            m_lvl    = '0;
            m_rise   = '0;
            m_fall   = '0;
            m_sticky = '0;
            for (int i = 0; i < N; i++) m_last[i] = cyc;
        end else begin
            sync   = m_p2;
            m_p2   = m_p1;
            m_p1   = raw_in ^ INV;
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < N; i++) begin
                if (sync[i] == m_lvl[i]) begin
                    m_last[i] = cyc;
                end else if (cyc - m_last[i] >= DC) begin
                    m_lvl[i]  = ~m_lvl[i];
                    m_last[i] = cyc;
                    if (m_lvl[i]) m_rise[i] = 1'b1;
                    else          m_fall[i] = 1'b1;
                end
            end
            m_sticky = m_rise | m_fall | (m_sticky & ~clear_mask);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s observed=%h expected=%h at cycle %0d",
                     tag, observed, expected, cyc);
        end
    endtask

    task automatic compareAll();
        checkOutput("level_out",    32'(level_out),    32'(m_lvl));
        checkOutput("rise_pulse",   32'(rise_pulse),   32'(m_rise));
        checkOutput("fall_pulse",   32'(fall_pulse),   32'(m_fall));
        checkOutput("event_sticky", 32'(event_sticky), 32'(m_sticky));
        checkOutput("any_event",    32'(any_event),    32'(|m_sticky));
        checkOutput("pulse_excl",   32'(rise_pulse & fall_pulse), 32'd0);
    endtask

    // Drive one cycle of inputs, let the edge happen, compare on the falling edge.
    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] c,
                                 input logic rst);
        raw_in     = r;
        clear_mask = c;
        reset      = rst;
        @(posedge clk);
        @(negedge clk);
        compareAll();
    endtask

    initial begin
        logic [3:0] r;
        logic [3:0] flip;
        raw_in     = 4'b1000;
        clear_mask = '0;
        reset      = 1'b1;

        // Reset held with the active-low pin idle
        for (int k = 0; k < 3; k++) applyStimulus(4'b1000, 4'b0000, 1'b1);
        checkOutput("t1_reset_outputs",
                    32'({level_out, rise_pulse, fall_pulse, event_sticky}), 32'd0);
        for (int k = 0; k < 12; k++) applyStimulus(4'b1000, 4'b0000, 1'b0);
        checkOutput("t1_any_event_idle", 32'(any_event), 32'd0);

        // Clean rise on channel 0
        for (int k = 0; k < 5; k++) applyStimulus(4'b1001, 4'b0000, 1'b0);
        checkOutput("t2_level_before", 32'(level_out[0]), 32'd0);
        applyStimulus(4'b1001, 4'b0000, 1'b0);
        checkOutput("t2_level",  32'(level_out), 32'b0001);
        checkOutput("t2_rise",   32'(rise_pulse), 32'b0001);
        checkOutput("t2_sticky", 32'(event_sticky), 32'b0001);
        checkOutput("t2_any",    32'(any_event), 32'd1);
        applyStimulus(4'b1001, 4'b0000, 1'b0);
        checkOutput("t2_rise_one_cycle", 32'(rise_pulse), 32'd0);

        // Bouncing channel 1: 3 high, 1 low, 3 high, low
        for (int k = 0; k < 3; k++) applyStimulus(4'b1011, 4'b0000, 1'b0);
        applyStimulus(4'b1001, 4'b0000, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(4'b1011, 4'b0000, 1'b0);
        for (int k = 0; k < 4; k++) applyStimulus(4'b1001, 4'b0000, 1'b0);
        checkOutput("t3_level_unchanged", 32'(level_out[1]), 32'd0);
        for (int k = 0; k < 5; k++) applyStimulus(4'b1011, 4'b0000, 1'b0);
        checkOutput("t3_rise_early", 32'(rise_pulse[1]), 32'd0);
        applyStimulus(4'b1011, 4'b0000, 1'b0);
        checkOutput("t3_rise", 32'(rise_pulse[1]), 32'd1);
        for (int k = 0; k < 10; k++) applyStimulus(4'b1001, 4'b0000, 1'b0);

        // Clear colliding with a fall strobe on channel 0
        for (int k = 0; k < 5; k++) applyStimulus(4'b1000, 4'b0000, 1'b0);
        applyStimulus(4'b1000, 4'b0001, 1'b0);
        checkOutput("t4_fall",        32'(fall_pulse[0]), 32'd1);
        checkOutput("t4_sticky_kept", 32'(event_sticky[0]), 32'd1);
        applyStimulus(4'b1000, 4'b1111, 1'b0);
        checkOutput("t4_sticky_clear", 32'(event_sticky), 32'd0);
        checkOutput("t4_any_clear",    32'(any_event), 32'd0);

        // Active-low channel 3
        for (int k = 0; k < 6; k++) applyStimulus(4'b0000, 4'b0000, 1'b0);
        checkOutput("t5_rise",  32'(rise_pulse[3]), 32'd1);
        checkOutput("t5_level", 32'(level_out[3]), 32'd1);
        for (int k = 0; k < 6; k++) applyStimulus(4'b1000, 4'b0000, 1'b0);
        checkOutput("t5_fall",  32'(fall_pulse[3]), 32'd1);
        for (int k = 0; k < 4; k++) applyStimulus(4'b1000, 4'b0000, 1'b0);

        // Reset in the middle of a channel 2 debounce
        applyStimulus(4'b1100, 4'b0000, 1'b0);
        applyStimulus(4'b1100, 4'b0000, 1'b0);
        applyStimulus(4'b1100, 4'b0000, 1'b1);
        checkOutput("t6_no_rise_pre_reset", 32'(rise_pulse[2]), 32'd0);
        for (int k = 0; k < 5; k++) applyStimulus(4'b1100, 4'b0000, 1'b0);
        checkOutput("t6_rise_early", 32'(rise_pulse[2]), 32'd0);
        applyStimulus(4'b1100, 4'b0000, 1'b0);
        checkOutput("t6_rise", 32'(rise_pulse[2]), 32'd1);

        // Random pin activity with occasional clears and rare resets
        r = 4'b1100;
        for (int k = 0; k < 600; k++) begin
            flip = '0;
            for (int i = 0; i < N; i++) flip[i] = ($urandom_range(0, 5) == 0);
            r = r ^ flip;
            applyStimulus(r, 4'($urandom_range(0, 15) & ($urandom_range(0, 3) == 0 ? 15 : 0)),
                          ($urandom_range(0, 199) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
